// File: rtl/sakebi_crc32_stream.sv
// Frame-aware CRC-32 (IEEE 802.3, reflected) over AXI4-Stream beats of 8..64 bits.
// Produces one buffered result per frame: FCS, good-residue flag and saturating byte count.
module sakebi_crc32_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    i_axis_ACLK,
    input  logic                    i_axis_ARESET,
    input  logic                    i_axis_TVALID,
    output logic                    o_axis_TREADY,
    input  logic [DATA_WIDTH-1:0]   i_axis_TDATA,
    input  logic [DATA_WIDTH/8-1:0] i_axis_TKEEP,
    input  logic                    i_axis_TLAST,
    output logic                    o_axis_TVALID,
    input  logic                    i_axis_TREADY,
    output logic [31:0]             o_axis_TDATA,
    output logic                    o_axis_TUSER,
    output logic [LEN_WIDTH-1:0]    o_frame_bytes
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [LEN_WIDTH+3:0] CNT_MAX = {4'b0000, {LEN_WIDTH{1'b1}}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } res_state_t;

    res_state_t state_p1;
    res_state_t state_next;

    logic [31:0]          crc_p0;
    logic [LEN_WIDTH-1:0] cnt_p0;

    logic [31:0]          crc_next;
    logic [LEN_WIDTH-1:0] cnt_next;
    logic [3:0]           keep_count;

    logic                 beat_accept;
    logic                 frame_end;
    logic                 vld_p1;

    logic [31:0]          res_fcs_p1;
    logic                 res_good_p1;
    logic [LEN_WIDTH-1:0] res_bytes_p1;

    // One byte through the reflected CRC: data bits enter LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc ^ {24'h000000, data};
        for (int b = 0; b < 8; b++) begin
            if (r[0]) begin
                r = (r >> 1) ^ CRC_POLY;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + 4'(keep[i]);
        end
        return n;
    endfunction

    // Widened add so a full 8-byte beat can never wrap before the clamp.
    function automatic logic [LEN_WIDTH-1:0] sat_add(input logic [LEN_WIDTH-1:0] a,
                                                     input logic [3:0]           n);
        logic [LEN_WIDTH+3:0] sum;
        sum = {4'b0000, a} + {{LEN_WIDTH{1'b0}}, n};
        if (sum > CNT_MAX) begin
            return {LEN_WIDTH{1'b1}};
        end
        return sum[LEN_WIDTH-1:0];
    endfunction

    assign vld_p1        = (state_p1 == FULL);
    assign o_axis_TVALID = vld_p1;
    assign o_axis_TREADY = ~vld_p1 | i_axis_TREADY;
    assign beat_accept   = i_axis_TVALID & o_axis_TREADY;
    assign frame_end     = beat_accept & i_axis_TLAST;

    assign o_axis_TDATA  = res_fcs_p1;
    assign o_axis_TUSER  = res_good_p1;
    assign o_frame_bytes = res_bytes_p1;

    // Lanes are folded in wire order 0..N-1 in a single combinational cascade.
    always_comb begin
        crc_next = crc_p0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (i_axis_TKEEP[i]) begin
                crc_next = crc_byte(crc_next, i_axis_TDATA[8*i +: 8]);
            end
        end
    end

    assign keep_count = keep_popcount(i_axis_TKEEP);
    assign cnt_next   = sat_add(cnt_p0, keep_count);

    // ---- stage p0: running CRC and byte count of the current frame ----
    always_ff @(posedge i_axis_ACLK) begin
        if (i_axis_ARESET) begin
            crc_p0 <= CRC_INIT;
            cnt_p0 <= '0;
        end else if (frame_end) begin
            crc_p0 <= CRC_INIT;
            cnt_p0 <= '0;
        end else if (beat_accept) begin
            crc_p0 <= crc_next;
            cnt_p0 <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_p1;
        case (state_p1)
            EMPTY: begin
                if (frame_end) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (frame_end) begin
                    state_next = FULL;
                end else if (i_axis_TREADY) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge i_axis_ACLK) begin
        if (i_axis_ARESET) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_next;
        end
    end

    // ---- stage p1: single-entry result buffer, held while unacknowledged ----
    always_ff @(posedge i_axis_ACLK) begin
        if (i_axis_ARESET) begin
            res_fcs_p1   <= '0;
            res_good_p1  <= 1'b0;
            res_bytes_p1 <= '0;
        end else if (frame_end) begin
            res_fcs_p1   <= ~crc_next;
            res_good_p1  <= (crc_next == CRC_RESIDUE);
            res_bytes_p1 <= cnt_next;
        end
    end

endmodule

// File: tb/tb_sakebi_crc32_stream.sv
// Scoreboard bench for sakebi_crc32_stream: directed frames push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_sakebi_crc32_stream;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int LW    = 4;
    localparam int BOUND = 60;

    logic          clk = 1'b0;
    logic          areset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          m_user;
    logic [LW-1:0] m_bytes;

    typedef struct {
        logic [31:0]   fcs;
        logic          good;
        logic [LW-1:0] bytes;
        bit            chk_fcs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sakebi_crc32_stream #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .i_axis_ACLK   (clk),
        .i_axis_ARESET (areset),
        .i_axis_TVALID (s_valid),
        .o_axis_TREADY (s_ready),
        .i_axis_TDATA  (s_data),
        .i_axis_TKEEP  (s_keep),
        .i_axis_TLAST  (s_last),
        .o_axis_TVALID (m_valid),
        .i_axis_TREADY (m_ready),
        .o_axis_TDATA  (m_data),
        .o_axis_TUSER  (m_user),
        .o_frame_bytes (m_bytes)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void expect_res(input logic [31:0] fcs, input logic good,
                                       input logic [LW-1:0] bytes, input bit chk_fcs);
        exp_t e;
        e.fcs     = fcs;
        e.good    = good;
        e.bytes   = bytes;
        e.chk_fcs = chk_fcs;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%h required=none", m_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk_fcs) chk("fcs", m_data, mon_e.fcs);
                chk("tuser", 32'(m_user), 32'(mon_e.good));
                chk("frame_bytes", 32'(m_bytes), 32'(mon_e.bytes));
            end
        end
    end

    // Presents one beat and holds it until the DUT accepts it (bounded).
    task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        int   n;
        logic rdy;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < BOUND);
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=stalled required=accepted");
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame_123456789();
        beat(32'h34333231, 4'b1111, 1'b0);
        beat(32'h38373635, 4'b1111, 1'b0);
        beat(32'h00000039, 4'b0001, 1'b1);
        expect_res(32'hCBF43926, 1'b0, 4'd9, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < BOUND) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        areset  = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_valid), 32'd0);
        chk("rst_tready", 32'(s_ready), 32'd1);
        chk("rst_tdata", m_data, 32'h00000000);
        chk("rst_tuser", 32'(m_user), 32'd0);
        chk("rst_bytes", 32'(m_bytes), 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Byte-per-beat "123456789" (8-bit style traffic).
        for (int i = 0; i < 9; i++) begin
            beat(32'(8'h31 + i), 4'b0001, (i == 8));
        end
        expect_res(32'hCBF43926, 1'b0, 4'd9, 1'b1);
        drain();

        // Full beats then a partial TLAST beat.
        frame_123456789();
        drain();

        // Data + FCS gives the good residue.
        beat(32'h34333231, 4'b1111, 1'b0);
        beat(32'h38373635, 4'b1111, 1'b0);
        beat(32'hF4392639, 4'b1111, 1'b0);
        beat(32'h000000CB, 4'b0001, 1'b1);
        expect_res(32'h2144DF1C, 1'b1, 4'd13, 1'b1);
        drain();

        // Same frame with one data bit flipped.
        beat(32'h34333230, 4'b1111, 1'b0);
        beat(32'h38373635, 4'b1111, 1'b0);
        beat(32'hF4392639, 4'b1111, 1'b0);
        beat(32'h000000CB, 4'b0001, 1'b1);
        expect_res(32'h0, 1'b0, 4'd13, 1'b0);
        drain();

        // Sparse TKEEP mid-frame, an all-zero TKEEP beat and idle cycles.
        beat(32'h34333231, 4'b1111, 1'b0);
        beat(32'h12345678, 4'b0000, 1'b0);
        beat(32'h36FF35EE, 4'b1010, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        beat(32'hAA393837, 4'b0111, 1'b1);
        expect_res(32'hCBF43926, 1'b0, 4'd9, 1'b1);
        drain();

        // Zero-byte frame.
        beat(32'hDEADBEEF, 4'b0000, 1'b1);
        expect_res(32'h00000000, 1'b0, 4'd0, 1'b1);
        drain();

        // Byte counter saturates at 15 with 16 bytes.
        for (int i = 0; i < 4; i++) begin
            beat(32'h01020304 * (i + 1), 4'b1111, (i == 3));
        end
        expect_res(32'h0, 1'b0, 4'd15, 1'b0);
        drain();

        // Back-to-back frames with no idle cycle between them.
        frame_123456789();
        frame_123456789();
        drain();

        // Backpressure: second frame stalls until the first result is taken.
        m_ready = 1'b0;
        beat(32'h00000000, 4'b0001, 1'b1);
        expect_res(32'hD202EF8D, 1'b0, 4'd1, 1'b1);
        fork
            frame_123456789();
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_tready", 32'(s_ready), 32'd0);
                    chk("hold_fcs", m_data, 32'hD202EF8D);
                    chk("hold_bytes", 32'(m_bytes), 32'd1);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();

        // Reset drops a pending result.
        m_ready = 1'b0;
        beat(32'h00000000, 4'b0001, 1'b1);
        @(negedge clk);
        chk("pending_before_reset", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        chk("reset_drop_tvalid", 32'(m_valid), 32'd0);
        chk("reset_drop_tdata", m_data, 32'h00000000);
        m_ready = 1'b1;

        // Reset mid-frame discards the partial frame.
        beat(32'h55AA55AA, 4'b1111, 1'b0);
        beat(32'h12345678, 4'b1111, 1'b0);
        pulse_reset();
        frame_123456789();
        drain();

        repeat (3) @(posedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
